bcd_to_binary_seq: RTL and testbench

Parametrised multi-digit packed-BCD to binary converter. Accepts NDIG BCD digits through a valid/ready handshake and accumulates them MSD-first, one digit per clock (acc = acc*10 + digit). Presents the binary result with a digit-validity error flag on a valid/ready output port. It is the sequential, multi-digit successor to the single-digit BCD decoders in the decoder set, and sits between BCD keypad/counter sources and binary datapaths.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_check.sv | 11 +
 rtl/bcd_to_binary_seq.sv | 88 ++++++++
 tb/tb_bcd_to_binary_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: converter state encoding, digit limit and a digit-validity helper
// reused by the BCD decoder family.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } conv_state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic is_bcd(input logic [3:0] digit);
      return digit <= BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational validity flag for one BCD digit: high when the nibble is 0..9.
module bcd_digit_check
   import bcd_pkg::*;
(
   input  logic [3:0] digit,
   output logic       valid
);

   assign valid = is_bcd(digit);

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter: accepts NDIG digits, accumulates MSD-first
// one digit per clock, and presents the result (or 0 with err) on a valid/ready port.
module bcd_to_binary_seq
   import bcd_pkg::*;
#(
   parameter  int NDIG  = 4,
   localparam int BIN_W = $clog2(10**NDIG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4*NDIG-1:0] bcd_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BIN_W-1:0]  bin_out,
   output logic              err
);

   localparam int WORD_W = 4 * NDIG;
   localparam int CNT_W  = $clog2(NDIG + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

   conv_state_t       state;
   logic [BIN_W-1:0]  acc;
   logic [BIN_W-1:0]  acc_next;
   logic [WORD_W-1:0] shift_reg;
   logic [CNT_W-1:0]  cnt;
   logic [BIN_W-1:0]  bin_r;
   logic              err_r;
   logic [NDIG-1:0]   digit_ok;
   logic              any_bad;

   for (genvar g = 0; g < NDIG; g++) begin : g_chk
      bcd_digit_check u_chk (
         .digit (bcd_in[4*g +: 4]),
         .valid (digit_ok[g])
      );
   end

   assign any_bad = |(~digit_ok);

   // acc*10 as shift-add; invalid digits are still accumulated, the output mux hides them
   assign acc_next = (acc << 3) + (acc << 1) + BIN_W'(shift_reg[WORD_W-1 -: 4]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         shift_reg <= '0;
         cnt       <= '0;
         bin_r     <= '0;
         err_r     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shift_reg <= bcd_in;
                  acc       <= '0;
                  cnt       <= '0;
                  err_r     <= any_bad;
                  bin_r     <= '0;
                  state     <= CONV;
               end
            end
            CONV: begin
               acc       <= acc_next;
               shift_reg <= shift_reg << 4;
               cnt       <= cnt + 1'b1;
               if (cnt == LAST_CNT) begin
                  bin_r <= err_r ? '0 : acc_next;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign bin_out   = bin_r;
   assign err       = err_r;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq with an NDIG=4 and an NDIG=1 instance.
module tb_bcd_to_binary_seq;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid4, in_ready4, out_valid4, out_ready4, err4;
   logic [15:0] bcd4;
   logic [13:0] bin4;

   logic        in_valid1, in_ready1, out_valid1, out_ready1, err1;
   logic [3:0]  bcd1;
   logic [3:0]  bin1;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   bcd_to_binary_seq #(.NDIG(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .bcd_in    (bcd4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .bin_out   (bin4),
      .err       (err4)
   );

   bcd_to_binary_seq #(.NDIG(1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .bcd_in    (bcd1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .bin_out   (bin1),
      .err       (err1)
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // accept one word on the NDIG=4 instance and return edges until out_valid
   task automatic start4(input logic [15:0] word, output int unsigned lat);
      check("in_ready4_before", 32'(in_ready4), 1);
      in_valid4 = 1'b1;
      bcd4      = word;
      tick();
      in_valid4 = 1'b0;
      check("out_valid4_after_accept", 32'(out_valid4), 0);
      lat = 0;
      while (!out_valid4 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic run4(input string tag, input logic [15:0] word,
                       input int unsigned exp_bin, input logic exp_err);
      int unsigned lat;
      out_ready4 = 1'b0;
      start4(word, lat);
      check({tag, "_lat"}, lat, 4);
      check({tag, "_bin"}, 32'(bin4), exp_bin);
      check({tag, "_err"}, 32'(err4), 32'(exp_err));
      out_ready4 = 1'b1;
      tick();
      check({tag, "_ov_drop"}, 32'(out_valid4), 0);
      check({tag, "_ir_back"}, 32'(in_ready4), 1);
      out_ready4 = 1'b0;
   endtask

   task automatic run1(input string tag, input logic [3:0] digit,
                       input int unsigned exp_bin, input logic exp_err);
      int unsigned lat;
      check({tag, "_ir"}, 32'(in_ready1), 1);
      in_valid1 = 1'b1;
      bcd1      = digit;
      tick();
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, lat, 1);
      check({tag, "_bin"}, 32'(bin1), exp_bin);
      check({tag, "_err"}, 32'(err1), 32'(exp_err));
      out_ready1 = 1'b1;
      tick();
      check({tag, "_ov_drop"}, 32'(out_valid1), 0);
      out_ready1 = 1'b0;
   endtask

   initial begin
      int unsigned lat;
      rst        = 1'b1;
      in_valid4  = 1'b0;
      out_ready4 = 1'b0;
      bcd4       = '0;
      in_valid1  = 1'b0;
      out_ready1 = 1'b0;
      bcd1       = '0;
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready4), 1);
      check("rst_out_valid", 32'(out_valid4), 0);
      check("rst_bin", 32'(bin4), 0);
      check("rst_err", 32'(err4), 0);
      check("rst1_in_ready", 32'(in_ready1), 1);
      rst = 1'b0;
      tick();

      run4("w1234", 16'h1234, 1234, 1'b0);
      run4("w9999", 16'h9999, 9999, 1'b0);
      run4("w0000", 16'h0000, 0, 1'b0);
      run4("w12A4", 16'h12A4, 0, 1'b1);
      run4("w0007", 16'h0007, 7, 1'b0);

      // backpressure: result must hold and new words must be refused
      out_ready4 = 1'b0;
      start4(16'h5678, lat);
      check("bp_lat", lat, 4);
      in_valid4 = 1'b1;
      bcd4      = 16'h1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_ov", 32'(out_valid4), 1);
         check("bp_bin", 32'(bin4), 5678);
         check("bp_err", 32'(err4), 0);
         check("bp_ir", 32'(in_ready4), 0);
      end
      out_ready4 = 1'b1;
      tick();
      check("bp_release_ov", 32'(out_valid4), 0);
      check("bp_release_ir", 32'(in_ready4), 1);
      out_ready4 = 1'b0;
      tick();
      in_valid4 = 1'b0;
      check("bp_new_accepted", 32'(in_ready4), 0);
      lat = 0;
      while (!out_valid4 && lat < 20) begin
         tick();
         lat++;
      end
      check("bp_new_lat", lat, 4);
      check("bp_new_bin", 32'(bin4), 1111);
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;

      // reset sampled on the second CONV edge aborts the conversion
      in_valid4 = 1'b1;
      bcd4      = 16'h5555;
      tick();
      in_valid4 = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ir", 32'(in_ready4), 1);
      check("abort_ov", 32'(out_valid4), 0);
      check("abort_bin", 32'(bin4), 0);
      check("abort_err", 32'(err4), 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_no_output", 32'(out_valid4), 0);
      end
      run4("w0042", 16'h0042, 42, 1'b0);

      run1("d1_9", 4'h9, 9, 1'b0);
      run1("d1_F", 4'hF, 0, 1'b1);
      run1("d1_0", 4'h0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
